// File: rtl/usb_bulk_ep_xfer_if.sv
// rtl/usb_bulk_ep_xfer_if.sv - transaction-layer token, OUT data, handshake and IN data signals
interface usb_bulk_ep_xfer_if;
    logic [1:0] trn_type;
    logic [3:0] trn_endpoint;
    logic       trn_start;
    logic [1:0] rx_data_type;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_end;
    logic       crc_error;
    logic [1:0] rx_hsk_type;
    logic       rx_hsk_recv;
    logic [1:0] tx_hsk_type;
    logic       tx_send_hsk;
    logic       tx_hsk_sent;
    logic [1:0] tx_data_type;
    logic       tx_data_start;
    logic [7:0] tx_data;
    logic       tx_data_valid;
    logic       tx_data_last;
    logic       tx_data_ready;

    modport slave (
        input  trn_type, trn_endpoint, trn_start,
        input  rx_data_type, rx_data, rx_valid, rx_end, crc_error,
        input  rx_hsk_type, rx_hsk_recv, tx_hsk_sent, tx_data_ready,
        output tx_hsk_type, tx_send_hsk, tx_data_type, tx_data_start,
        output tx_data, tx_data_valid, tx_data_last
    );

    modport master (
        output trn_type, trn_endpoint, trn_start,
        output rx_data_type, rx_data, rx_valid, rx_end, crc_error,
        output rx_hsk_type, rx_hsk_recv, tx_hsk_sent, tx_data_ready,
        input  tx_hsk_type, tx_send_hsk, tx_data_type, tx_data_start,
        input  tx_data, tx_data_valid, tx_data_last
    );
endinterface

// File: rtl/usb_bulk_ep_xfer.sv
// rtl/usb_bulk_ep_xfer.sv - bulk endpoint transfer engine: toggles, STALL/NAK, duplicate OUT, IN ack timeout
// Optional USB_BULK_PING_EN: answer PING tokens and reply NYET to a committed OUT when the endpoint fills.
module usb_bulk_ep_xfer #(
    parameter int NUM_EP      = 4,
    parameter int MAX_PKT     = 512,
    parameter int ACK_TIMEOUT = 1024
) (
    input  logic                  clk,
    input  logic                  rst,
    usb_bulk_ep_xfer_if.slave     bus,
    input  logic [NUM_EP-1:0]     ep_halt_i,
    input  logic [NUM_EP-1:0]     clear_toggle_i,
    input  logic [NUM_EP-1:0]     in_has_data_i,
    input  logic [8*NUM_EP-1:0]   in_data_i,
    input  logic [NUM_EP-1:0]     in_valid_i,
    input  logic [NUM_EP-1:0]     in_last_i,
    output logic [NUM_EP-1:0]     in_ready_o,
    output logic [NUM_EP-1:0]     in_ack_o,
    input  logic [NUM_EP-1:0]     out_ready_i,
    output logic [7:0]            out_data_o,
    output logic [NUM_EP-1:0]     out_valid_o,
    output logic [NUM_EP-1:0]     out_commit_o,
    output logic [NUM_EP-1:0]     out_drop_o
);
    localparam int EPW = (NUM_EP > 1) ? $clog2(NUM_EP) : 1;
    localparam int TW  = $clog2(ACK_TIMEOUT + 1);
    localparam logic [10:0] LAST_BEAT = 11'(MAX_PKT - 1);
    localparam logic [10:0] MAX_BEAT  = 11'(MAX_PKT);
    localparam logic [TW-1:0] TMO_LAST = TW'(ACK_TIMEOUT - 1);

    localparam logic [1:0] TOK_OUT  = 2'b00;
    localparam logic [1:0] TOK_IN   = 2'b10;
`ifdef USB_BULK_PING_EN
    localparam logic [1:0] TOK_PING = 2'b01;
`endif
    localparam logic [1:0] HSK_ACK   = 2'b00;
    localparam logic [1:0] HSK_NAK   = 2'b10;
    localparam logic [1:0] HSK_STALL = 2'b11;
`ifdef USB_BULK_PING_EN
    localparam logic [1:0] HSK_NYET  = 2'b01;
`endif

    typedef enum logic [2:0] {
        S_IDLE, S_IN_DATA, S_IN_WAIT, S_OUT_DATA, S_HSK
    } state_t;

    state_t            state_q, state_d;
    logic [EPW-1:0]    ep_q, ep_d;
    logic [1:0]        resp_q, resp_d;
    logic [1:0]        hsk_q, hsk_d;
    logic [10:0]       cnt_q, cnt_d;
    logic [TW-1:0]     tmo_q, tmo_d;
    logic [NUM_EP-1:0] in_tog_q, in_tog_d;
    logic [NUM_EP-1:0] out_tog_q, out_tog_d;
    logic [NUM_EP-1:0] ack_q, commit_q, drop_q;
    logic              in_flip, out_flip, ack_d, commit_d, drop_d;

    // Token-time endpoint lookup (before ep_q is latched)
    logic [3:0]     ep_m1;
    logic [EPW-1:0] tok_idx;
    logic           tok_valid, tok_halt, tok_has, tok_ordy;

    // Lookups for the latched endpoint
    logic [NUM_EP-1:0] ep_oh;
    logic [7:0]        sel_data;
    logic              sel_valid, sel_last, sel_ordy, sel_in_tog, sel_out_tog;

    logic        beat_acc, beat_last, fwd, oversize;
    logic [11:0] rx_total;

    assign ep_m1     = bus.trn_endpoint - 4'd1;
    assign tok_idx   = ep_m1[EPW-1:0];
    assign tok_valid = bus.trn_start && (bus.trn_endpoint != 4'd0) &&
                       (int'(bus.trn_endpoint) <= NUM_EP);
    assign rx_total  = {1'b0, cnt_q} + 12'(bus.rx_valid);
    assign oversize  = rx_total > 12'(MAX_PKT);

    always_comb begin
        tok_halt    = 1'b0;
        tok_has     = 1'b0;
        tok_ordy    = 1'b0;
        ep_oh       = '0;
        sel_data    = 8'h00;
        sel_valid   = 1'b0;
        sel_last    = 1'b0;
        sel_ordy    = 1'b0;
        sel_in_tog  = 1'b0;
        sel_out_tog = 1'b0;
        for (int i = 0; i < NUM_EP; i++) begin
            if (tok_idx == EPW'(i)) begin
                tok_halt = ep_halt_i[i];
                tok_has  = in_has_data_i[i];
                tok_ordy = out_ready_i[i];
            end
            if (ep_q == EPW'(i)) begin
                ep_oh[i]    = 1'b1;
                sel_data    = in_data_i[8*i +: 8];
                sel_valid   = in_valid_i[i];
                sel_last    = in_last_i[i];
                sel_ordy    = out_ready_i[i];
                sel_in_tog  = in_tog_q[i];
                sel_out_tog = out_tog_q[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            ep_q      <= '0;
            resp_q    <= HSK_ACK;
            hsk_q     <= HSK_ACK;
            cnt_q     <= '0;
            tmo_q     <= '0;
            in_tog_q  <= '0;
            out_tog_q <= '0;
            ack_q     <= '0;
            commit_q  <= '0;
            drop_q    <= '0;
        end else begin
            state_q   <= state_d;
            ep_q      <= ep_d;
            resp_q    <= resp_d;
            hsk_q     <= hsk_d;
            cnt_q     <= cnt_d;
            tmo_q     <= tmo_d;
            in_tog_q  <= in_tog_d;
            out_tog_q <= out_tog_d;
            ack_q     <= ack_d    ? ep_oh : '0;
            commit_q  <= commit_d ? ep_oh : '0;
            drop_q    <= drop_d   ? ep_oh : '0;
        end
    end

    always_comb begin
        state_d  = state_q;
        ep_d     = ep_q;
        resp_d   = resp_q;
        hsk_d    = hsk_q;
        cnt_d    = cnt_q;
        tmo_d    = tmo_q;
        in_flip  = 1'b0;
        out_flip = 1'b0;
        ack_d    = 1'b0;
        commit_d = 1'b0;
        drop_d   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (tok_valid) begin
                    ep_d  = tok_idx;
                    cnt_d = '0;
                    case (bus.trn_type)
                        TOK_IN: begin
                            if (tok_halt) begin
                                hsk_d   = HSK_STALL;
                                state_d = S_HSK;
                            end else if (!tok_has) begin
                                hsk_d   = HSK_NAK;
                                state_d = S_HSK;
                            end else begin
                                state_d = S_IN_DATA;
                            end
                        end
                        TOK_OUT: begin
                            resp_d  = tok_halt ? HSK_STALL : (tok_ordy ? HSK_ACK : HSK_NAK);
                            state_d = S_OUT_DATA;
                        end
`ifdef USB_BULK_PING_EN
                        TOK_PING: begin
                            hsk_d   = tok_halt ? HSK_STALL : (tok_ordy ? HSK_ACK : HSK_NAK);
                            state_d = S_HSK;
                        end
`endif
                        default: ;
                    endcase
                end
            end
            S_IN_DATA: begin
                if (beat_acc) begin
                    cnt_d = cnt_q + 11'd1;
                    if (beat_last) begin
                        tmo_d   = '0;
                        state_d = S_IN_WAIT;
                    end
                end
            end
            S_IN_WAIT: begin
                if (bus.rx_hsk_recv) begin
                    if (bus.rx_hsk_type == HSK_ACK) begin
                        in_flip = 1'b1;
                        ack_d   = 1'b1;
                    end
                    state_d = S_IDLE;
                end else if (tmo_q == TMO_LAST) begin
                    state_d = S_IDLE;
                end else begin
                    tmo_d = tmo_q + TW'(1);
                end
            end
            S_OUT_DATA: begin
                if (bus.rx_end) begin
                    if (bus.crc_error || oversize) begin
                        drop_d  = 1'b1;
                        state_d = S_IDLE;
                    end else if (resp_q != HSK_ACK) begin
                        hsk_d   = resp_q;
                        state_d = S_HSK;
                    end else if (bus.rx_data_type != {sel_out_tog, 1'b0}) begin
                        // Host missed our previous ACK and resent: acknowledge, keep nothing
                        drop_d  = 1'b1;
                        hsk_d   = HSK_ACK;
                        state_d = S_HSK;
                    end else begin
                        commit_d = 1'b1;
                        out_flip = 1'b1;
`ifdef USB_BULK_PING_EN
                        hsk_d    = sel_ordy ? HSK_ACK : HSK_NYET;
`else
                        hsk_d    = HSK_ACK;
`endif
                        state_d  = S_HSK;
                    end
                end else if (bus.rx_valid && (cnt_q != 11'h7ff)) begin
                    cnt_d = cnt_q + 11'd1;
                end
            end
            S_HSK: begin
                if (bus.tx_hsk_sent) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // clear_toggle is applied after the flip so it wins when both land together
    always_comb begin
        in_tog_d  = (in_tog_q  ^ (in_flip  ? ep_oh : '0)) & ~clear_toggle_i;
        out_tog_d = (out_tog_q ^ (out_flip ? ep_oh : '0)) & ~clear_toggle_i;
    end

    always_comb begin
        bus.tx_data_start = (state_q == S_IN_DATA);
        bus.tx_data_valid = bus.tx_data_start && sel_valid;
        bus.tx_data       = bus.tx_data_valid ? sel_data : 8'h00;
        beat_last         = sel_last || (cnt_q == LAST_BEAT);
        bus.tx_data_last  = bus.tx_data_valid && beat_last;
        bus.tx_data_type  = bus.tx_data_start ? {sel_in_tog, 1'b0} : 2'b00;
        beat_acc          = bus.tx_data_valid && bus.tx_data_ready;
        bus.tx_send_hsk   = (state_q == S_HSK);
        bus.tx_hsk_type   = hsk_q;
        in_ready_o        = beat_acc ? ep_oh : '0;
        fwd               = (state_q == S_OUT_DATA) && bus.rx_valid &&
                            (resp_q == HSK_ACK) && (cnt_q < MAX_BEAT);
        out_valid_o       = fwd ? ep_oh : '0;
        out_data_o        = fwd ? bus.rx_data : 8'h00;
        in_ack_o          = ack_q;
        out_commit_o      = commit_q;
        out_drop_o        = drop_q;
    end
endmodule

// File: tb/tb_usb_bulk_ep_xfer.sv
// tb/tb_usb_bulk_ep_xfer.sv - directed self-checking bench for usb_bulk_ep_xfer
module tb_usb_bulk_ep_xfer;
    localparam int NUM_EP = 4;
    localparam int MAX_PKT = 512;
    localparam int ACK_TIMEOUT = 1024;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    usb_bulk_ep_xfer_if bus();
    logic [3:0]  ep_halt, clear_toggle, in_has_data, in_valid, in_last, in_ready, in_ack;
    logic [3:0]  out_ready, out_valid, out_commit, out_drop;
    logic [31:0] in_data;
    logic [7:0]  out_data;

    usb_bulk_ep_xfer #(.NUM_EP(NUM_EP), .MAX_PKT(MAX_PKT), .ACK_TIMEOUT(ACK_TIMEOUT)) dut (
        .clk(clk), .rst(rst), .bus(bus),
        .ep_halt_i(ep_halt), .clear_toggle_i(clear_toggle), .in_has_data_i(in_has_data),
        .in_data_i(in_data), .in_valid_i(in_valid), .in_last_i(in_last),
        .in_ready_o(in_ready), .in_ack_o(in_ack), .out_ready_i(out_ready),
        .out_data_o(out_data), .out_valid_o(out_valid),
        .out_commit_o(out_commit), .out_drop_o(out_drop)
    );

    int checks = 0;
    int errors = 0;
    int ack_seen = 0;
    int src_idx;
    bit src_stalled;

`ifdef USB_BULK_PING_EN
    localparam bit PING_EN = 1'b1;
`else
    localparam bit PING_EN = 1'b0;
`endif

    typedef struct {
        logic [1:0] typ;
        logic [3:0] ep;
        logic [3:0] halt;
        logic [3:0] has;
        logic [3:0] ordy;
        logic       exp_send;
        logic [1:0] exp_type;
        logic       exp_start;
    } vec_t;
    vec_t vecs[8];

    always @(negedge clk) if (in_ack != 4'b0) ack_seen++;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] pat(input int k);
        return 8'(17 * (k + 1));
    endfunction

    task automatic set_src(input int i_ep, input int avail);
        in_data[8*i_ep +: 8] = pat(src_idx);
        in_last[i_ep] = (src_idx == avail - 1);
        if (src_idx == 1 && !src_stalled) begin
            in_valid[i_ep] = 1'b0;
            src_stalled = 1'b1;
        end else begin
            in_valid[i_ep] = 1'b1;
        end
    endtask

    task automatic in_xfer(input int epn, input int avail, input logic tog, input int exp_n);
        int  i_ep = epn - 1;
        int  bad = 0;
        bit  done = 0;
        src_idx = 0;
        src_stalled = 0;
        in_has_data[i_ep] = 1'b1;
        set_src(i_ep, avail);
        bus.trn_type = 2'b10;
        bus.trn_endpoint = 4'(epn);
        bus.trn_start = 1'b1;
        cyc();
        bus.trn_start = 1'b0;
        #2;
        chk("in_start", 32'(bus.tx_data_start), 1);
        chk("in_first_valid", 32'(bus.tx_data_valid), 1);
        chk("in_pid", 32'(bus.tx_data_type), {30'b0, tog, 1'b0});
        for (int n = 0; n < 3000 && !done; n++) begin
            if (bus.tx_data_valid) begin
                if (bus.tx_data !== pat(src_idx)) bad++;
                if (bus.tx_data_last !== (src_idx == exp_n - 1)) bad++;
                if (in_ready !== 4'(1 << i_ep)) bad++;
                if (bus.tx_data_last) done = 1;
                src_idx++;
            end else if (in_ready !== 4'b0) begin
                bad++;
            end
            cyc();
            if (!done) begin
                set_src(i_ep, avail);
                #2;
            end
        end
        #2;
        chk("in_beats", src_idx, exp_n);
        chk("in_bytes", bad, 0);
        chk("in_start_fall", 32'(bus.tx_data_start), 0);
        in_valid = '0;
        in_last = '0;
        in_has_data = '0;
    endtask

    task automatic ack_in(input int epn, input logic clr);
        bus.rx_hsk_type = 2'b00;
        bus.rx_hsk_recv = 1'b1;
        clear_toggle = clr ? 4'(1 << (epn - 1)) : 4'b0;
        cyc();
        bus.rx_hsk_recv = 1'b0;
        clear_toggle = '0;
        #2;
        chk("in_ack_pulse", 32'(in_ack), 1 << (epn - 1));
        cyc();
        #2;
        chk("in_ack_clear", 32'(in_ack), 0);
    endtask

    task automatic out_xfer(input string nm, input int epn, input logic tog, input int nbytes,
                            input logic crc, input logic ordy_end, input logic exp_fwd,
                            input logic [1:0] exp_pulse, input logic exp_send,
                            input logic [1:0] exp_type);
        int i_ep = epn - 1;
        int bad = 0;
        bit expf;
        bus.trn_type = 2'b00;
        bus.trn_endpoint = 4'(epn);
        bus.trn_start = 1'b1;
        cyc();
        bus.trn_start = 1'b0;
        for (int k = 0; k < nbytes; k++) begin
            bus.rx_valid = 1'b1;
            bus.rx_data = pat(k) ^ 8'h5a;
            #2;
            expf = exp_fwd && (k < MAX_PKT);
            if (out_valid !== (expf ? 4'(1 << i_ep) : 4'b0)) bad++;
            if (expf && out_data !== (pat(k) ^ 8'h5a)) bad++;
            cyc();
        end
        bus.rx_valid = 1'b0;
        bus.rx_end = 1'b1;
        bus.crc_error = crc;
        bus.rx_data_type = {tog, 1'b0};
        if (!ordy_end) out_ready[i_ep] = 1'b0;
        cyc();
        bus.rx_end = 1'b0;
        bus.crc_error = 1'b0;
        out_ready = '1;
        #2;
        chk({nm, "_fwd"}, bad, 0);
        chk({nm, "_commit"}, 32'(out_commit), exp_pulse[1] ? (1 << i_ep) : 0);
        chk({nm, "_drop"}, 32'(out_drop), exp_pulse[0] ? (1 << i_ep) : 0);
        chk({nm, "_send"}, 32'(bus.tx_send_hsk), 32'(exp_send));
        if (exp_send) begin
            chk({nm, "_type"}, 32'(bus.tx_hsk_type), 32'(exp_type));
            bus.tx_hsk_sent = 1'b1;
            cyc();
            bus.tx_hsk_sent = 1'b0;
        end else begin
            cyc();
        end
        #2;
        chk({nm, "_idle"}, 32'(bus.tx_send_hsk), 0);
    endtask

    initial begin
        int acks0;
        rst = 1'b1;
        bus.trn_type = 2'b00; bus.trn_endpoint = 4'd0; bus.trn_start = 1'b0;
        bus.rx_data_type = 2'b00; bus.rx_data = 8'h00; bus.rx_valid = 1'b0;
        bus.rx_end = 1'b0; bus.crc_error = 1'b0; bus.rx_hsk_type = 2'b00;
        bus.rx_hsk_recv = 1'b0; bus.tx_hsk_sent = 1'b0; bus.tx_data_ready = 1'b1;
        ep_halt = '0; clear_toggle = '0; in_has_data = '0; in_data = '0;
        in_valid = '0; in_last = '0; out_ready = '1;

        //            typ    ep     halt     has      ordy     send  type            start
        vecs[0] = '{2'b10, 4'd1, 4'b0001, 4'b0000, 4'b1111, 1'b1, 2'b11, 1'b0};
        vecs[1] = '{2'b10, 4'd4, 4'b0000, 4'b0000, 4'b1111, 1'b1, 2'b10, 1'b0};
        vecs[2] = '{2'b10, 4'd0, 4'b0000, 4'b1111, 4'b1111, 1'b0, 2'b00, 1'b0};
        vecs[3] = '{2'b10, 4'd5, 4'b0000, 4'b1111, 4'b1111, 1'b0, 2'b00, 1'b0};
        vecs[4] = '{2'b11, 4'd2, 4'b0000, 4'b1111, 4'b1111, 1'b0, 2'b00, 1'b0};
        vecs[5] = '{2'b01, 4'd2, 4'b0000, 4'b0000, 4'b1111, PING_EN, 2'b00, 1'b0};
        vecs[6] = '{2'b01, 4'd3, 4'b0100, 4'b0000, 4'b1111, PING_EN, 2'b11, 1'b0};
        vecs[7] = '{2'b10, 4'd3, 4'b0100, 4'b1111, 4'b1111, 1'b1, 2'b11, 1'b0};

        cyc(); cyc();
        #2;
        chk("rst_tx", {26'b0, bus.tx_send_hsk, bus.tx_hsk_type, bus.tx_data_start,
                       bus.tx_data_valid, bus.tx_data_last}, 0);
        chk("rst_tx_data", {22'b0, bus.tx_data, bus.tx_data_type}, 0);
        chk("rst_ep", {16'b0, in_ready, in_ack, out_valid, out_commit}, 0);
        chk("rst_out", {20'b0, out_drop, out_data}, 0);
        rst = 1'b0;
        cyc();

        for (int v = 0; v < 8; v++) begin
            ep_halt = vecs[v].halt;
            in_has_data = vecs[v].has;
            out_ready = vecs[v].ordy;
            bus.trn_type = vecs[v].typ;
            bus.trn_endpoint = vecs[v].ep;
            bus.trn_start = 1'b1;
            cyc();
            bus.trn_start = 1'b0;
            #2;
            chk($sformatf("vec%0d_send", v), 32'(bus.tx_send_hsk), 32'(vecs[v].exp_send));
            chk($sformatf("vec%0d_start", v), 32'(bus.tx_data_start), 32'(vecs[v].exp_start));
            if (vecs[v].exp_send) begin
                chk($sformatf("vec%0d_type", v), 32'(bus.tx_hsk_type), 32'(vecs[v].exp_type));
                bus.tx_hsk_sent = 1'b1;
                cyc();
                bus.tx_hsk_sent = 1'b0;
                #2;
                chk($sformatf("vec%0d_idle", v), 32'(bus.tx_send_hsk), 0);
            end
            ep_halt = '0; in_has_data = '0; out_ready = '1;
            cyc();
        end

        // IN ep2: DATA0 then DATA1, then clear_toggle racing the ACK flip
        in_xfer(2, 3, 1'b0, 3);
        ack_in(2, 1'b0);
        in_xfer(2, 3, 1'b1, 3);
        ack_in(2, 1'b0);
        in_xfer(2, 3, 1'b0, 3);
        ack_in(2, 1'b1);
        in_xfer(2, 3, 1'b0, 3);
        ack_in(2, 1'b0);

        // IN ep1: truncated at MAX_PKT, host never answers, retry keeps DATA0
        acks0 = ack_seen;
        in_xfer(1, 600, 1'b0, 512);
        for (int n = 0; n < ACK_TIMEOUT + 10; n++) cyc();
        bus.rx_hsk_type = 2'b00;
        bus.rx_hsk_recv = 1'b1;
        cyc();
        bus.rx_hsk_recv = 1'b0;
        cyc();
        chk("timeout_no_ack", ack_seen - acks0, 0);
        in_xfer(1, 3, 1'b0, 3);
        ack_in(1, 1'b0);

        // OUT: commit, duplicate, next toggle, CRC error, STALL, NAK, oversize, NYET
        out_xfer("o3a", 3, 1'b0, 4, 1'b0, 1'b1, 1'b1, 2'b10, 1'b1, 2'b00);
        out_xfer("o3b", 3, 1'b0, 4, 1'b0, 1'b1, 1'b1, 2'b01, 1'b1, 2'b00);
        out_xfer("o3c", 3, 1'b1, 2, 1'b0, 1'b1, 1'b1, 2'b10, 1'b1, 2'b00);
        out_xfer("ocrc", 1, 1'b0, 3, 1'b1, 1'b1, 1'b1, 2'b01, 1'b0, 2'b00);
        ep_halt = 4'b0001;
        out_xfer("ostall", 1, 1'b0, 3, 1'b0, 1'b1, 1'b0, 2'b00, 1'b1, 2'b11);
        ep_halt = '0;
        out_ready = 4'b1101;
        out_xfer("onak", 2, 1'b0, 2, 1'b0, 1'b1, 1'b0, 2'b00, 1'b1, 2'b10);
        out_xfer("obig", 4, 1'b0, MAX_PKT + 1, 1'b0, 1'b1, 1'b1, 2'b01, 1'b0, 2'b00);
        out_xfer("onyet", 4, 1'b0, 2, 1'b0, 1'b0, 1'b1, 2'b10, 1'b1, PING_EN ? 2'b01 : 2'b00);

        // Reset mid-packet on ep1 (IN toggle is DATA1 before this)
        acks0 = ack_seen;
        src_idx = 0;
        src_stalled = 1;
        in_has_data[0] = 1'b1;
        set_src(0, 3);
        bus.trn_type = 2'b10;
        bus.trn_endpoint = 4'd1;
        bus.trn_start = 1'b1;
        cyc();
        bus.trn_start = 1'b0;
        cyc();
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        in_valid = '0; in_has_data = '0; in_last = '0;
        #2;
        chk("rst_mid_start", 32'(bus.tx_data_start), 0);
        chk("rst_mid_pulses", {20'b0, in_ack, out_commit, out_drop}, 0);
        cyc();
        chk("rst_mid_no_ack", ack_seen - acks0, 0);
        in_xfer(1, 3, 1'b0, 3);
        ack_in(1, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
